// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer
// Moves one frame at a time around an external Sobel engine. The frame is
// streamed into the engine's input memory, the engine is started, the
// sequencer waits for it to finish, and then the result memory is streamed
// back out through a 2-entry skid buffer.
// Optional feature: define SOBEL_SEQ_WATCHDOG_EN to add a WAIT-state watchdog
// that parks the block in a sticky ERROR state after TIMEOUT_CYCLES cycles.
module sobel_frame_sequencer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int PIXEL_COUNT    = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  error_o,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  sobel_start_o,
  input  logic                  sobel_finish_i,
  output logic                  wr_en_imem_o,
  output logic [ADDR_WIDTH-1:0] addr_imem_o,
  output logic [DATA_WIDTH-1:0] data_imem_o,
  output logic                  rd_en_omem_o,
  output logic [ADDR_WIDTH-1:0] addr_omem_o,
  input  logic [DATA_WIDTH-1:0] data_omem_i
);

  // One extra counter bit so a frame filling the whole address space
  // can still be counted up to PIXEL_COUNT without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PIXEL_COUNT - 1);
  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(PIXEL_COUNT);

`ifdef SOBEL_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_KICK, ST_WAIT, ST_UNLOAD, ST_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_KICK, ST_WAIT, ST_UNLOAD
  } state_t;
`endif

  state_t state_q, state_d;

  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // A read issued last cycle has its data on data_omem_i this cycle.
  logic in_flight_q, in_flight_d;
  logic in_flight_last_q, in_flight_last_d;

  logic [1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [1:0]                 buf_last_q, buf_last_d;
  logic                       buf_wr_ptr_q, buf_wr_ptr_d;
  logic                       buf_rd_ptr_q, buf_rd_ptr_d;
  logic [1:0]                 buf_count_q, buf_count_d;

`ifdef SOBEL_SEQ_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  logic       pop;
  logic       issue;
  logic [2:0] occ_after;

  // Next-state, counter, buffer and output logic; all outputs held low while rst_i is high.
  always_comb begin
    state_d          = state_q;
    load_cnt_d       = load_cnt_q;
    rd_cnt_d         = rd_cnt_q;
    in_flight_d      = in_flight_q;
    in_flight_last_d = in_flight_last_q;
    buf_data_d       = buf_data_q;
    buf_last_d       = buf_last_q;
    buf_wr_ptr_d     = buf_wr_ptr_q;
    buf_rd_ptr_d     = buf_rd_ptr_q;
    buf_count_d      = buf_count_q;
`ifdef SOBEL_SEQ_WATCHDOG_EN
    wd_cnt_d         = wd_cnt_q;
`endif
    busy_o        = 1'b0;
    frame_done_o  = 1'b0;
    error_o       = 1'b0;
    s_ready_o     = 1'b0;
    m_valid_o     = 1'b0;
    m_data_o      = '0;
    m_last_o      = 1'b0;
    sobel_start_o = 1'b0;
    wr_en_imem_o  = 1'b0;
    addr_imem_o   = '0;
    data_imem_o   = '0;
    rd_en_omem_o  = 1'b0;
    addr_omem_o   = '0;
    pop           = 1'b0;
    issue         = 1'b0;
    occ_after     = '0;

    if (!rst_i) begin
      busy_o = (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
          end
        end
        ST_LOAD: begin
          s_ready_o = 1'b1;
          if (s_valid_i) begin
            wr_en_imem_o = 1'b1;
            addr_imem_o  = load_cnt_q[ADDR_WIDTH-1:0];
            data_imem_o  = s_data_i;
            load_cnt_d   = load_cnt_q + CNT_W'(1);
            if (load_cnt_q == LAST_IDX) begin
              state_d = ST_KICK;
            end
          end
        end
        ST_KICK: begin
          sobel_start_o = 1'b1;
          rd_cnt_d      = '0;
`ifdef SOBEL_SEQ_WATCHDOG_EN
          wd_cnt_d      = '0;
`endif
          state_d       = ST_WAIT;
        end
        ST_WAIT: begin
          if (sobel_finish_i) begin
            state_d = ST_UNLOAD;
          end
`ifdef SOBEL_SEQ_WATCHDOG_EN
          else if (wd_cnt_q == WD_LIMIT) begin
            state_d = ST_ERROR;
          end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
          end
`endif
        end
        ST_UNLOAD: begin
          m_valid_o = (buf_count_q != 2'd0);
          if (m_valid_o) begin
            m_data_o = buf_data_q[buf_rd_ptr_q];
            m_last_o = buf_last_q[buf_rd_ptr_q];
          end
          pop = m_valid_o && m_ready_i;
          // Entries held plus the one landing this cycle, minus one leaving now.
          occ_after = {1'b0, buf_count_q} + {2'b00, in_flight_q} - {2'b00, pop};
          issue = (rd_cnt_q < PIX_TOTAL) && (occ_after < 3'd2);
          if (issue) begin
            rd_en_omem_o = 1'b1;
            addr_omem_o  = rd_cnt_q[ADDR_WIDTH-1:0];
            rd_cnt_d     = rd_cnt_q + CNT_W'(1);
          end
          in_flight_d      = issue;
          in_flight_last_d = issue && (rd_cnt_q == LAST_IDX);
          if (in_flight_q) begin
            buf_data_d[buf_wr_ptr_q] = data_omem_i;
            buf_last_d[buf_wr_ptr_q] = in_flight_last_q;
            buf_wr_ptr_d             = ~buf_wr_ptr_q;
          end
          if (pop) begin
            buf_rd_ptr_d = ~buf_rd_ptr_q;
          end
          buf_count_d = buf_count_q + {1'b0, in_flight_q} - {1'b0, pop};
          if (pop && m_last_o) begin
            frame_done_o = 1'b1;
            state_d      = ST_IDLE;
          end
        end
`ifdef SOBEL_SEQ_WATCHDOG_EN
        ST_ERROR: begin
          error_o = 1'b1;
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and skid buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      load_cnt_q       <= '0;
      rd_cnt_q         <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      buf_data_q       <= '0;
      buf_last_q       <= '0;
      buf_wr_ptr_q     <= 1'b0;
      buf_rd_ptr_q     <= 1'b0;
      buf_count_q      <= '0;
`ifdef SOBEL_SEQ_WATCHDOG_EN
      wd_cnt_q         <= '0;
`endif
    end else begin
      state_q          <= state_d;
      load_cnt_q       <= load_cnt_d;
      rd_cnt_q         <= rd_cnt_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
      buf_data_q       <= buf_data_d;
      buf_last_q       <= buf_last_d;
      buf_wr_ptr_q     <= buf_wr_ptr_d;
      buf_rd_ptr_q     <= buf_rd_ptr_d;
      buf_count_q      <= buf_count_d;
`ifdef SOBEL_SEQ_WATCHDOG_EN
      wd_cnt_q         <= wd_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Testbench for sobel_frame_sequencer with a 16-pixel frame. Load, kick and
// wait phases come from a table of per-cycle vectors; the unload phases and
// the reset-during-unload case are hand-written sequences dispatched from it.
module tb_sobel_frame_sequencer;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int NPIX = 16;
  localparam int TMO  = 50;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          busy_o, frame_done_o, error_o;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_ready_i = 1'b0;
  logic          sobel_start_o;
  logic          sobel_finish_i = 1'b0;
  logic          wr_en_imem_o;
  logic [AW-1:0] addr_imem_o;
  logic [DW-1:0] data_imem_o;
  logic          rd_en_omem_o;
  logic [AW-1:0] addr_omem_o;
  logic [DW-1:0] data_omem_i = '0;

  int total = 0;
  int bad   = 0;

  // Row op: 0 = single table cycle, 1 = unload with m_ready held high,
  // 2 = unload with m_ready 1,0,0,1 pattern, 3 = reset during unload.
  typedef struct {
    int            op;
    logic          rst, en, sv;
    logic [DW-1:0] sd;
    logic          fin;
    logic          e_busy, e_sready, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_start, e_err;
  } vec_t;

  vec_t tbl[$];

  always #5 clk_i = ~clk_i;

  sobel_frame_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIXEL_COUNT(NPIX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .error_o(error_o),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .sobel_start_o(sobel_start_o), .sobel_finish_i(sobel_finish_i),
    .wr_en_imem_o(wr_en_imem_o), .addr_imem_o(addr_imem_o), .data_imem_o(data_imem_o),
    .rd_en_omem_o(rd_en_omem_o), .addr_omem_o(addr_omem_o), .data_omem_i(data_omem_i)
  );

  // Result memory contents: a bijective pattern so misordered reads show up.
  function automatic logic [DW-1:0] omemF(input int a);
    return 8'((a * 37 + 27) & 255);
  endfunction

  // Result memory model: data for a read appears on the following cycle.
  always @(posedge clk_i) begin
    data_omem_i <= rd_en_omem_o ? omemF(int'(addr_omem_o)) : 8'hEE;
  end

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (step %0d): got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic add(input int op, input logic rst, en, sv, input logic [DW-1:0] sd, input logic fin,
                     input logic b, r, w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic st, er);
    vec_t v;
    v.op = op; v.rst = rst; v.en = en; v.sv = sv; v.sd = sd; v.fin = fin;
    v.e_busy = b; v.e_sready = r; v.e_wr = w; v.e_addr = a; v.e_data = d;
    v.e_start = st; v.e_err = er;
    tbl.push_back(v);
  endtask

  task automatic addReset(input logic sv);
    add(0, 1, 1, sv, 8'h3C, 1, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic addIdle(input logic en, input logic sv);
    add(0, 0, en, sv, 8'h99, 1, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic addLoad(input int i, input logic [DW-1:0] d);
    add(0, 0, 0, 1, d, 0, 1, 1, 1, AW'(i), d, 0, 0);
  endtask

  task automatic addGap();
    add(0, 0, 1, 0, 8'h55, 1, 1, 1, 0, '0, '0, 0, 0);
  endtask

  task automatic addKick();
    add(0, 0, 1, 1, 8'h21, 0, 1, 0, 0, '0, '0, 1, 0);
  endtask

  task automatic addWait(input logic fin, input logic en);
    add(0, 0, en, 1, 8'h77, fin, 1, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic addOp(input int op);
    add(op, 0, 0, 0, '0, 0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic fillTable();
    // Reset, idle, then a back-to-back frame; finish 20 cycles after start.
    addReset(0); addReset(1);
    addIdle(0, 1); addIdle(1, 0);
    for (int i = 0; i < NPIX; i++) addLoad(i, DW'(i));
    addKick();
    for (int i = 0; i < 18; i++) addWait(0, 0);
    addWait(0, 1);
    addWait(1, 0);
    addOp(1);
    // Frame with s_valid gaps, stray finish in LOAD, stalled unload.
    addIdle(1, 0);
    for (int i = 0; i < NPIX; i++) begin
      addLoad(i, DW'(8'h80 + i));
      if (i < NPIX - 1) addGap();
    end
    addKick();
    addWait(1, 0);
    addOp(2);
    // Reset on the 8th load handshake, reload from address 0, reset mid-unload.
    addIdle(1, 0);
    for (int i = 0; i < 7; i++) addLoad(i, DW'(8'h40 + i));
    addReset(1);
    addIdle(0, 1);
    addIdle(1, 0);
    for (int i = 0; i < NPIX; i++) addLoad(i, DW'(8'h40 + i));
    addKick();
    addWait(1, 0);
    addOp(3);
    // Clean frame after the unload reset: buffer state must be fresh.
    addIdle(1, 0);
    for (int i = 0; i < NPIX; i++) addLoad(i, DW'(8'hF0 - i));
    addKick();
    addWait(1, 0);
    addOp(1);
    // Engine never finishes.
    addIdle(1, 0);
    for (int i = 0; i < NPIX; i++) addLoad(i, DW'(i * 3));
    addKick();
`ifdef SOBEL_SEQ_WATCHDOG_EN
    for (int i = 0; i < TMO; i++) addWait(0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 8'h12, 1, 1, 0, 0, '0, '0, 0, 1);
    addReset(0);
    addIdle(0, 0);
`else
    for (int i = 0; i < 60; i++) addWait(0, 0);
    addWait(1, 0);
    addOp(2);
`endif
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk_i); #1;
    rst_i = v.rst; enable_i = v.en; s_valid_i = v.sv; s_data_i = v.sd;
    sobel_finish_i = v.fin; m_ready_i = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    @(negedge clk_i);
    chk("busy", n, busy_o, v.e_busy);
    chk("s_ready", n, s_ready_o, v.e_sready);
    chk("wr_en", n, wr_en_imem_o, v.e_wr);
    chk("addr_imem", n, addr_imem_o, v.e_addr);
    chk("data_imem", n, data_imem_o, v.e_data);
    chk("start", n, sobel_start_o, v.e_start);
    chk("error", n, error_o, v.e_err);
    chk("m_valid idle", n, m_valid_o, 0);
    chk("m_last idle", n, m_last_o, 0);
    chk("frame_done idle", n, frame_done_o, 0);
    chk("rd_en idle", n, rd_en_omem_o, 0);
    chk("addr_omem idle", n, addr_omem_o, 0);
  endtask

  task automatic idleInputs();
    rst_i = 0; enable_i = 0; s_valid_i = 0; sobel_finish_i = 0;
  endtask

  task automatic runUnload(input int mode);
    int k = 0, nrd = 0, first_rd = -1, first_v = -1, first_hs = -1, last_hs = -1;
    logic held_v = 1'b0;
    logic [DW-1:0] held_d = '0;
    for (int j = 0; j < 300 && k < NPIX; j++) begin
      @(posedge clk_i); #1;
      idleInputs();
      m_ready_i = (mode == 0) ? 1'b1 : ((j % 4 == 0) || (j % 4 == 3));
      @(negedge clk_i);
      if (held_v) begin
        chk("stall valid", j, m_valid_o, 1);
        chk("stall data", j, m_data_o, held_d);
      end
      if (rd_en_omem_o) begin
        if (first_rd < 0) first_rd = j;
        chk("rd addr", j, addr_omem_o, nrd);
        chk("rd/wr exclusive", j, wr_en_imem_o, 0);
        nrd++;
      end
      held_v = 1'b0;
      if (m_valid_o) begin
        if (first_v < 0) first_v = j;
        if (m_ready_i) begin
          chk("out data", j, m_data_o, omemF(k));
          chk("out last", j, m_last_o, (k == NPIX - 1));
          chk("frame done", j, frame_done_o, (k == NPIX - 1));
          if (first_hs < 0) first_hs = j;
          last_hs = j;
          k++;
        end else begin
          held_v = 1'b1;
          held_d = m_data_o;
          chk("done while stalled", j, frame_done_o, 0);
        end
      end
    end
    chk("pixels out", mode, k, NPIX);
    chk("reads issued", mode, nrd, NPIX);
    if (mode == 0) begin
      chk("first latency", mode, first_v - first_rd, 2);
      chk("burst span", mode, last_hs - first_hs, NPIX - 1);
    end
    @(posedge clk_i); #1;
    m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("post busy", mode, busy_o, 0);
    chk("post valid", mode, m_valid_o, 0);
    chk("post rd_en", mode, rd_en_omem_o, 0);
    chk("post done", mode, frame_done_o, 0);
    m_ready_i = 1'b0;
  endtask

  task automatic midUnloadReset();
    for (int j = 0; j < 3; j++) begin
      @(posedge clk_i); #1;
      idleInputs();
      m_ready_i = 1'b0;
      @(negedge clk_i);
      chk("mid rd_en", j, rd_en_omem_o, (j < 2));
      if (j < 2) chk("mid rd addr", j, addr_omem_o, j);
      if (j == 2) begin
        chk("mid valid", j, m_valid_o, 1);
        chk("mid data", j, m_data_o, omemF(0));
      end
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1; m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rst busy", 3, busy_o, 0);
    chk("rst valid", 3, m_valid_o, 0);
    chk("rst data", 3, m_data_o, 0);
    chk("rst done", 3, frame_done_o, 0);
    chk("rst rd_en", 3, rd_en_omem_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("after rst busy", 4, busy_o, 0);
    chk("after rst valid", 4, m_valid_o, 0);
    chk("after rst done", 4, frame_done_o, 0);
    m_ready_i = 1'b0;
  endtask

  initial begin
    fillTable();
    $display("[TB] running %0d table rows", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        1: runUnload(0);
        2: runUnload(1);
        3: midUnloadReset();
        default: begin
          applyStimulus(tbl[i]);
          checkOutput(tbl[i], i);
        end
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_frame_sequencer.md
SOBEL_FRAME_SEQUENCER -- requirements
Module: sobel_frame_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-003 SHALL have parameter PIXEL_COUNT, default 4096, pixels per frame (rows*columns), 2..2**ADDR_WIDTH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, watchdog limit in cycles (used only under REQ-031).
REQ-005 SHALL have ports: clk_i  in  1  sole clock, rising edge; rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: enable_i  in  1  arm one frame; busy_o  out  1  not IDLE; frame_done_o  out  1  one-cycle completion pulse; error_o  out  1  watchdog error.
REQ-007 SHALL have input stream ports: s_valid_i  in  1; s_data_i  in  DATA_WIDTH; s_ready_o  out  1.
REQ-008 SHALL have output stream ports: m_valid_o  out  1; m_data_o  out  DATA_WIDTH; m_last_o  out  1  final pixel; m_ready_i  in  1.
REQ-009 SHALL have engine ports: sobel_start_o  out  1; sobel_finish_i  in  1; wr_en_imem_o  out  1; addr_imem_o  out  ADDR_WIDTH; data_imem_o  out  DATA_WIDTH; rd_en_omem_o  out  1; addr_omem_o  out  ADDR_WIDTH; data_omem_i  in  DATA_WIDTH (valid one cycle after rd_en_omem_o).

Function
REQ-010 SHALL implement states IDLE, LOAD, KICK, WAIT, UNLOAD (plus ERROR per REQ-031).
REQ-011 IDLE: enable_i=1 SHALL move to LOAD next cycle, clearing pixel counter; enable_i ignored in all other states.
REQ-012 LOAD: s_ready_o SHALL be 1; each s_valid_i&s_ready_o cycle SHALL drive wr_en_imem_o=1, addr_imem_o=counter, data_imem_o=s_data_i combinationally, then increment counter.
REQ-013 LOAD SHALL go to KICK on the handshake at counter=PIXEL_COUNT-1; s_ready_o SHALL be 0 outside LOAD.
REQ-014 KICK SHALL assert sobel_start_o for exactly one cycle, then go to WAIT.
REQ-015 WAIT SHALL go to UNLOAD on the first cycle sobel_finish_i=1; sobel_finish_i SHALL be ignored in other states.
REQ-016 UNLOAD SHALL issue reads for addr_omem_o=0..PIXEL_COUNT-1 in order, one per cycle max, with a 2-entry output buffer.
REQ-017 Read SHALL issue only when buffer occupancy + reads in flight < 2, counting a same-cycle m_valid_o&m_ready_i pop as freeing an entry.
REQ-018 With m_ready_i held 1, UNLOAD SHALL sustain one pixel per cycle after 2-cycle initial latency (first rd_en_omem_o to first m_valid_o).
REQ-019 m_valid_o/m_data_o SHALL be stable while m_valid_o=1 and m_ready_i=0; no pixel dropped or duplicated.
REQ-020 m_last_o SHALL equal 1 exactly with the pixel from address PIXEL_COUNT-1.
REQ-021 Final output handshake SHALL pulse frame_done_o for one cycle and return to IDLE the same edge.
REQ-022 addr_*/data_imem_o SHALL be 0 when respective enable is 0; wr_en_imem_o and rd_en_omem_o never both 1.
REQ-023 Counters SHALL be ADDR_WIDTH+1 bits to avoid wrap at PIXEL_COUNT=2**ADDR_WIDTH.

Reset
REQ-024 rst_i=1 at a rising edge SHALL force IDLE, clear counters, buffer and in-flight tracking, regardless of state.
REQ-025 During and after reset all outputs SHALL be 0 (busy_o, frame_done_o, error_o, s_ready_o, m_valid_o, m_last_o, sobel_start_o, enables, addresses, data).
REQ-026 Reset mid-LOAD or mid-UNLOAD SHALL discard the frame; no frame_done_o pulse.
REQ-027 busy_o SHALL be 1 in every non-IDLE state.

Configuration
REQ-030 Macro SOBEL_SEQ_WATCHDOG_EN SHALL control the WAIT watchdog.
REQ-031 Defined: cycle counter runs in WAIT; reaching TIMEOUT_CYCLES without sobel_finish_i SHALL enter ERROR, error_o=1 sticky, busy_o=1, until rst_i.
REQ-032 Undefined: no ERROR state or counter; WAIT lasts indefinitely; error_o tied 0.

Verification (PIXEL_COUNT=16, DATA_WIDTH=8)
REQ-040 Pixels 0x00..0x0F streamed back-to-back -> 16 writes addr 0..15, one sobel_start_o pulse 1 cycle after last write.
REQ-041 finish_i raised 20 cycles after start, m_ready_i=1 -> 16 outputs on consecutive cycles, data matches omem model, m_last_o on 16th, frame_done_o on its handshake.
REQ-042 m_ready_i toggling 1,0,0,1 repeating -> all 16 pixels in order, data stable during stalls, no extra rd_en_omem_o beyond 16.
REQ-043 s_valid_i gaps (every other cycle) -> writes only on handshake cycles, addresses contiguous 0..15.
REQ-044 rst_i pulsed at 8th LOAD handshake -> all outputs 0 next cycle, new frame loads from addr 0.
REQ-045 SOBEL_SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=50, finish_i never raised -> error_o=1 at cycle 50 of WAIT, held until rst_i.
